// File: rtl/iob_fifo2stream_pkg.sv
// Shared constants for the FIFO read-side stream stage: buffer depth, FIFO read
// latency and the width of the buffered-word counter.
package iob_fifo2stream_pkg;

  localparam int IOB_FIFO2STREAM_DEPTH  = 2;
  localparam int IOB_FIFO2STREAM_RD_LAT = 1;

  function automatic int iob_fifo2stream_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int IOB_FIFO2STREAM_CNT_W = iob_fifo2stream_cnt_w(IOB_FIFO2STREAM_DEPTH);

  // One bit per cycle of FIFO read latency that a word can be in flight.
  typedef logic [IOB_FIFO2STREAM_RD_LAT-1:0] inflight_t;

endpackage

// File: rtl/iob_stream_buf2.sv
// Two-entry register buffer with wrapping 1-bit head/tail pointers and an occupancy count.
// A push while full and not popping is never requested by the parent and is not guarded here.
module iob_stream_buf2
  import iob_fifo2stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_push,
  input  logic [DATA_W-1:0]                i_data,
  input  logic                             i_pop,
  output logic [DATA_W-1:0]                o_data,
  output logic                             o_valid,
  output logic [IOB_FIFO2STREAM_CNT_W-1:0] o_cnt
);

  logic [DATA_W-1:0]                r_mem [IOB_FIFO2STREAM_DEPTH];
  logic                             r_head;
  logic                             r_tail;
  logic [IOB_FIFO2STREAM_CNT_W-1:0] r_cnt;
  logic                             w_pop;

  assign w_pop = i_pop & (r_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_head];
  assign o_valid = (r_cnt != '0);
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/iob_fifo2stream.sv
// FIFO empty/read_en to valid/ready stream adapter with a 2-word skid buffer.
// Optional packet framing (m_last from cfg_len) is enabled by IOB_FIFO2STREAM_LAST_EN.
module iob_fifo2stream
  import iob_fifo2stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_read_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        level
`ifdef IOB_FIFO2STREAM_LAST_EN
  ,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              m_last
`endif
);

  // Stream handshake: a word transfers on any cycle with m_valid & m_ready; while
  // m_valid is high and m_ready low, m_data/m_valid hold unchanged.
  inflight_t                        r_inflight;
  logic [IOB_FIFO2STREAM_CNT_W-1:0] w_cnt;
  logic [2:0]                       w_occ;
  logic                             w_pop;
  logic                             w_read_en;

  assign w_pop = m_valid & m_ready;
  assign w_occ = {1'b0, w_cnt} + {2'b00, r_inflight};

  // Only read when the word is guaranteed a slot once it lands a cycle later.
  assign w_read_en = ~fifo_empty &
                     ((w_occ < 3'd2) | ((w_occ == 3'd2) & w_pop));
  assign fifo_read_en = w_read_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_read_en;
    end
  end

  iob_stream_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight[0]),
    .i_data  (fifo_data),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_valid (m_valid),
    .o_cnt   (w_cnt)
  );

  assign level = w_cnt;

`ifdef IOB_FIFO2STREAM_LAST_EN
  logic [LEN_W-1:0] r_pkt_cnt;
  logic [LEN_W-1:0] w_len_m1;

  // A zero length behaves as length one: every word closes its own packet.
  assign w_len_m1 = (cfg_len == '0) ? '0 : cfg_len - 1'b1;
  assign m_last   = m_valid & (r_pkt_cnt == w_len_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (w_pop) begin
      r_pkt_cnt <= m_last ? '0 : r_pkt_cnt + 1'b1;
    end
  end
`endif

endmodule
